// File: rtl/trig_stream_sink.sv
// Receive end of the L1 trigger stream. Decodes trigger/heartbeat words, queues triggers
// for the event builder, keeps saturating per-beam counters and watches for a silent link.
module trig_stream_sink #(
  parameter int NBEAMS     = 2,
  parameter int HB_TIMEOUT = 1024
) (
  input  logic              ifclk,
  input  logic              ifclk_rstn,
  input  logic [31:0]       s_trig_tdata,
  input  logic              s_trig_tvalid,
  output logic              s_trig_tready,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [14:0]       evt_time_o,
  output logic [NBEAMS-1:0] evt_mask_o,
  output logic [14:0]       last_hb_o,
  input  logic [3:0]        cnt_sel_i,
  output logic [31:0]       cnt_o,
  input  logic              cnt_clr_i,
  output logic              stall_o
);

  localparam int DEPTH  = 4;
  localparam int IDLE_W = $clog2(HB_TIMEOUT + 1);

  typedef struct packed {
    logic [14:0]       ts;
    logic [NBEAMS-1:0] mask;
  } evt_t;

  logic                    is_trig;
  logic [14:0]             word_ts;
  logic [NBEAMS-1:0]       word_mask;
  logic [15:0]             unused_mask_bits;
  logic                    accept;
  logic                    push;
  logic                    pop;
  evt_t                    mem [DEPTH];
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              count;
  logic [NBEAMS-1:0][31:0] cnt_q;
  logic [31:0]             cnt_sel_val;
  logic [IDLE_W-1:0]       idle_q;

  assign is_trig          = s_trig_tdata[31];
  assign word_ts          = s_trig_tdata[30:16];
  assign word_mask        = s_trig_tdata[NBEAMS-1:0];
  // Mask bits above NBEAMS are don't-care on the wire.
  assign unused_mask_bits = s_trig_tdata[15:0];

  // Ready depends on occupancy alone, so heartbeats also wait while the queue is full.
  assign s_trig_tready = (count != 3'(DEPTH));
  assign accept        = s_trig_tvalid && s_trig_tready;
  assign push          = accept && is_trig && (word_mask != '0);
  assign evt_valid_o   = (count != 3'd0);
  assign pop           = evt_valid_o && evt_ready_i;
  assign evt_time_o    = mem[rd_ptr].ts;
  assign evt_mask_o    = mem[rd_ptr].mask;

  // NOTE: the storage array is reset so the head reads 0 after reset and nothing
  // from before a mid-stream reset can ever reappear at the outputs.
  always_ff @(posedge ifclk) begin
    if (!ifclk_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{ts: word_ts, mask: word_mask};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge ifclk) begin
    if (!ifclk_rstn || cnt_clr_i) begin
      cnt_q <= '0;
    end else if (push) begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (word_mask[b] && (cnt_q[b] != 32'hFFFF_FFFF)) cnt_q[b] <= cnt_q[b] + 32'd1;
      end
    end
  end

  // NOTE: default assignment first keeps this mux free of inferred latches.
  always_comb begin
    cnt_sel_val = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (cnt_sel_i == 4'(b)) cnt_sel_val = cnt_q[b];
    end
  end

  always_ff @(posedge ifclk) begin
    if (!ifclk_rstn) begin
      cnt_o     <= '0;
      last_hb_o <= '0;
      idle_q    <= '0;
    end else begin
      cnt_o <= cnt_sel_val;
      if (accept && !is_trig) last_hb_o <= word_ts;
      if (accept) idle_q <= '0;
      else if (idle_q != IDLE_W'(HB_TIMEOUT)) idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign stall_o = (idle_q == IDLE_W'(HB_TIMEOUT));

endmodule

// File: tb/tb_trig_stream_sink.sv
// Bench for trig_stream_sink: directed scenarios followed by randomized traffic, all
// checked every cycle against a queue/array model of the trigger sink.
module tb_trig_stream_sink;

  localparam int NB = 2;
  localparam int HB = 16;

  logic          ifclk;
  logic          ifclk_rstn;
  logic [31:0]   s_trig_tdata;
  logic          s_trig_tvalid;
  logic          s_trig_tready;
  logic          evt_valid_o;
  logic          evt_ready_i;
  logic [14:0]   evt_time_o;
  logic [NB-1:0] evt_mask_o;
  logic [14:0]   last_hb_o;
  logic [3:0]    cnt_sel_i;
  logic [31:0]   cnt_o;
  logic          cnt_clr_i;
  logic          stall_o;

  trig_stream_sink #(.NBEAMS(NB), .HB_TIMEOUT(HB)) dut (
    .ifclk        (ifclk),
    .ifclk_rstn   (ifclk_rstn),
    .s_trig_tdata (s_trig_tdata),
    .s_trig_tvalid(s_trig_tvalid),
    .s_trig_tready(s_trig_tready),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_time_o   (evt_time_o),
    .evt_mask_o   (evt_mask_o),
    .last_hb_o    (last_hb_o),
    .cnt_sel_i    (cnt_sel_i),
    .cnt_o        (cnt_o),
    .cnt_clr_i    (cnt_clr_i),
    .stall_o      (stall_o)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  typedef struct {
    logic [14:0]   ts;
    logic [NB-1:0] mask;
  } evt_m_t;

  evt_m_t      m_q[$];
  longint      m_cnt[NB];
  logic [14:0] m_hb;
  logic [31:0] m_cnt_o;
  int          m_since;
  bit          m_last_acc;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the tb-driven inputs and model state.
  task automatic model_edge();
    bit            acc;
    logic [NB-1:0] mk;
    if (!ifclk_rstn) begin
      m_q.delete();
      foreach (m_cnt[b]) m_cnt[b] = 0;
      m_hb       = '0;
      m_cnt_o    = '0;
      m_since    = 0;
      m_last_acc = 1'b0;
      return;
    end
    acc     = s_trig_tvalid && (m_q.size() < 4);
    mk      = s_trig_tdata[NB-1:0];
    m_cnt_o = (int'(cnt_sel_i) < NB) ? 32'(m_cnt[cnt_sel_i]) : 32'd0;
    if (m_q.size() > 0 && evt_ready_i) m_q.delete(0);
    if (acc && s_trig_tdata[31] && mk != '0) m_q.push_back('{s_trig_tdata[30:16], mk});
    if (cnt_clr_i) begin
      foreach (m_cnt[b]) m_cnt[b] = 0;
    end else if (acc && s_trig_tdata[31]) begin
      foreach (m_cnt[b]) if (mk[b] && m_cnt[b] < 64'hFFFF_FFFF) m_cnt[b]++;
    end
    if (acc && !s_trig_tdata[31]) m_hb = s_trig_tdata[30:16];
    m_since    = acc ? 0 : m_since + 1;
    m_last_acc = acc;
  endtask

  task automatic compare_all();
    check("tready", s_trig_tready, m_q.size() < 4);
    check("evt_valid", evt_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("evt_time", evt_time_o, m_q[0].ts);
      check("evt_mask", evt_mask_o, m_q[0].mask);
    end
    check("last_hb", last_hb_o, m_hb);
    check("cnt_o", cnt_o, m_cnt_o);
    check("stall", stall_o, m_since >= HB);
  endtask

  task automatic tick();
    @(posedge ifclk);
    model_edge();
    @(negedge ifclk);
    compare_all();
  endtask

  task automatic send(input logic [31:0] w, input int budget);
    int n = 0;
    s_trig_tvalid = 1'b1;
    s_trig_tdata  = w;
    do begin
      tick();
      n++;
    end while (!m_last_acc && n < budget);
    check("send_accepted", m_last_acc, 1'b1);
    s_trig_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words[6];
    logic [31:0] c1;
    int          sent;
    int          budget;
    int          kind;

    ifclk_rstn    = 1'b0;
    s_trig_tdata  = '0;
    s_trig_tvalid = 1'b0;
    evt_ready_i   = 1'b0;
    cnt_sel_i     = '0;
    cnt_clr_i     = 1'b0;
    repeat (2) tick();
    check("rst_evt_time", evt_time_o, 15'd0);
    check("rst_evt_mask", evt_mask_o, '0);
    check("rst_cnt_o", cnt_o, 32'd0);
    check("rst_tready", s_trig_tready, 1'b1);
    ifclk_rstn = 1'b1;

    // Idle link after reset: watchdog trips after HB edges.
    repeat (HB - 1) tick();
    check("stall_before", stall_o, 1'b0);
    tick();
    check("stall_at_timeout", stall_o, 1'b1);

    // Heartbeat clears the watchdog, updates last_hb, produces no event.
    send(32'h0123_0000, 4);
    check("stall_cleared", stall_o, 1'b0);
    check("hb_value", last_hb_o, 15'h0123);
    check("hb_no_event", evt_valid_o, 1'b0);

    // First trigger: visible one cycle after accept.
    send(32'h8005_0003, 4);
    check("first_valid", evt_valid_o, 1'b1);
    check("first_time", evt_time_o, 15'h0005);
    check("first_mask", evt_mask_o, 2'b11);
    evt_ready_i = 1'b1;
    cnt_sel_i   = 4'd0;
    repeat (2) tick();
    check("cnt0_first", cnt_o, 32'd1);
    cnt_sel_i = 4'd1;
    repeat (2) tick();
    check("cnt1_first", cnt_o, 32'd1);

    // Six back-to-back triggers against a stalled consumer.
    evt_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = {1'b1, 15'(16'h0100 + i), 14'd0, 2'(i % 3 + 1)};
    sent   = 0;
    budget = 0;
    s_trig_tvalid = 1'b1;
    s_trig_tdata  = words[0];
    while (sent < 6 && budget < 60) begin
      if (budget == 10) evt_ready_i = 1'b1;
      tick();
      budget++;
      if (m_last_acc) begin
        sent++;
        if (sent == 4) check("tready_full", s_trig_tready, 1'b0);
        if (sent < 6) s_trig_tdata = words[sent];
      end
    end
    s_trig_tvalid = 1'b0;
    check("six_words_sent", sent, 6);
    repeat (8) tick();

    // Counter saturation from a preloaded near-full value.
    c1 = 32'(m_cnt[1]);
    force dut.cnt_q = {c1, 32'hFFFF_FFFE};
    #1;
    release dut.cnt_q;
    m_cnt[0] = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) send({1'b1, 15'(i), 16'h0001}, 4);
    cnt_sel_i = 4'd0;
    repeat (2) tick();
    check("cnt0_saturated", cnt_o, 32'hFFFF_FFFF);

    // Clear wins over an increment in the same cycle; event still delivered.
    evt_ready_i = 1'b0;
    repeat (2) tick();
    cnt_clr_i = 1'b1;
    send(32'h8007_0001, 4);
    cnt_clr_i = 1'b0;
    check("clr_evt_valid", evt_valid_o, 1'b1);
    check("clr_evt_time", evt_time_o, 15'h0007);
    evt_ready_i = 1'b1;
    repeat (2) tick();
    check("cnt0_cleared", cnt_o, 32'd0);

    // Out-of-range selects read zero.
    cnt_sel_i = 4'd9;
    repeat (2) tick();
    check("sel_out_of_range", cnt_o, 32'd0);

    // Randomized traffic with a mid-stream reset.
    for (int it = 0; it < 1500; it++) begin
      if (!s_trig_tvalid || m_last_acc) begin
        s_trig_tvalid = ($urandom_range(0, 3) != 0);
        kind = int'($urandom_range(0, 9));
        s_trig_tdata = $urandom;
        if (kind < 6) s_trig_tdata[31] = 1'b1;
        else if (kind < 8) s_trig_tdata[31] = 1'b0;
        else begin
          s_trig_tdata[31]     = 1'b1;
          s_trig_tdata[NB-1:0] = '0;
        end
      end
      evt_ready_i = ($urandom_range(0, 9) < 6);
      cnt_sel_i   = 4'($urandom_range(0, 3));
      cnt_clr_i   = ($urandom_range(0, 63) == 0);
      ifclk_rstn  = !(it >= 700 && it < 702);
      if (!ifclk_rstn) s_trig_tvalid = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
